// File: rtl/invsqrt_rr_scheduler.sv
// rtl/invsqrt_rr_scheduler.sv - round-robin front end sharing one fixed-latency inverse-sqrt core
// Optional feature macro: INVSQRT_SCHED_FLAG_EN (adds rsp_err and operand classification)
module invsqrt_rr_scheduler #(
  parameter int NUM_REQ  = 4,
  parameter int ID_W     = 2,
  parameter int CORE_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*32-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [31:0]           core_din,
  input  logic [31:0]           core_dout,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_data,
`ifdef INVSQRT_SCHED_FLAG_EN
  output logic                  rsp_err,
`endif
  output logic                  busy
);

  localparam int LAST = CORE_LAT - 1;

  logic [31:0]     slice [NUM_REQ];
  logic [ID_W-1:0] ptr;
  logic            grant_any;
  logic [ID_W-1:0] grant_id;
  logic [31:0]     grant_data;
  logic [ID_W-1:0] idx;

  // Tag pipe travels alongside the core so each result knows its owner.
  logic [CORE_LAT-1:0] tag_vld;
  logic [ID_W-1:0]     tag_id [CORE_LAT];

`ifdef INVSQRT_SCHED_FLAG_EN
  logic                grant_err;
  logic [CORE_LAT-1:0] tag_err;
`endif

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign slice[i] = req_data[32*i +: 32];
  end

  // Round-robin search starting at ptr; first valid requester wins.
  always_comb begin
    grant_any  = 1'b0;
    grant_id   = '0;
    grant_data = '0;
    idx        = '0;
    req_ready  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (!grant_any && req_valid[idx]) begin
        grant_any  = 1'b1;
        grant_id   = idx;
        grant_data = slice[idx];
      end
    end
    if (grant_any) begin
      req_ready[grant_id] = 1'b1;
    end
  end

`ifdef INVSQRT_SCHED_FLAG_EN
  // Operands the core cannot handle: negatives (nonzero magnitude), zero/denormal, inf/NaN.
  always_comb begin
    grant_err = (grant_data[31] && (grant_data[30:0] != 31'd0)) ||
                (grant_data[30:23] == 8'h00) ||
                (grant_data[30:23] == 8'hFF);
  end
`endif

  // Capture the granted operand and advance the pointer past the winner.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_din <= '0;
      ptr      <= '0;
    end else if (grant_any) begin
      core_din <= grant_data;
      ptr      <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end

  // Shift the tag pipe every cycle; a bubble enters when nothing was granted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_vld <= '0;
      for (int s = 0; s < CORE_LAT; s++) begin
        tag_id[s] <= '0;
      end
`ifdef INVSQRT_SCHED_FLAG_EN
      tag_err <= '0;
`endif
    end else begin
      tag_vld[0] <= grant_any;
      tag_id[0]  <= grant_id;
`ifdef INVSQRT_SCHED_FLAG_EN
      tag_err[0] <= grant_any & grant_err;
`endif
      for (int s = 1; s < CORE_LAT; s++) begin
        tag_vld[s] <= tag_vld[s-1];
        tag_id[s]  <= tag_id[s-1];
`ifdef INVSQRT_SCHED_FLAG_EN
        tag_err[s] <= tag_err[s-1];
`endif
      end
    end
  end

  // Register the core result with its owner when the matching tag reaches the end.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid <= '0;
      rsp_id    <= '0;
      rsp_data  <= '0;
`ifdef INVSQRT_SCHED_FLAG_EN
      rsp_err   <= 1'b0;
`endif
    end else if (tag_vld[LAST]) begin
      rsp_valid <= NUM_REQ'(1) << tag_id[LAST];
      rsp_id    <= tag_id[LAST];
`ifdef INVSQRT_SCHED_FLAG_EN
      rsp_data  <= tag_err[LAST] ? 32'h7FC00000 : core_dout;
      rsp_err   <= tag_err[LAST];
`else
      rsp_data  <= core_dout;
`endif
    end else begin
      rsp_valid <= '0;
    end
  end

  // Busy while anything sits in the tag pipe or the response register.
  always_comb begin
    busy = (|tag_vld) | (|rsp_valid);
  end

endmodule
